pipe_operand_loader: RTL and testbench
======================================

# pipe_operand_loader

Upstream feeder for the 3-stage pipe_ex arithmetic pipeline (f = (a+b) + (c-d) + d). It accepts operand words one at a time over a valid/ready stream and assembles them into a four-operand set. On the pipeline's clock edge it presents the set on a, b, c, d as a single stable launch. It also tracks launches through the pipeline latency, so it can flag the cycle in which the matching f is valid, and it counts issued sets.

## Interface
- N, 10, operand/result width; must equal the pipeline's N.
- LAT, 3, pipeline latency in clock edges from operand sampling to valid f.
- CW, 8, width of issue counter.

- clk  input  1  rising-edge clock, shared with the pipeline.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a valid operand word.
- in_data  input  N  operand word; order on the stream is a, b, c, d.
- in_ready  output  1  loader accepts in_data this cycle.
- issue_en  input  1  downstream permission to launch; gates acceptance of the d word only.
- flush  input  1  synchronous; discards a partially assembled set.
- a, b, c, d  output  N each  operand set driven to the pipeline; registered.
- op_valid  output  1  one-cycle pulse; a..d hold a newly launched set this cycle.
- res_valid  output  1  pipeline output f corresponds to a launched set this cycle.
- in_flight  output  2  launches not yet retired; range 0..LAT.
- issue_cnt  output  CW  total sets launched; wraps modulo 2^CW.

## Operation
- FSM states: S_A, S_B, S_C, S_D, one per expected word. Reset state is S_A.
- A word is accepted on a rising edge when in_valid && in_ready.
- in_ready is 1 in S_A, S_B and S_C, provided flush = 0.
- In S_D, in_ready = issue_en && !flush.
- Accepting a word in S_A, S_B or S_C stores it in shadow register sa, sb or sc and advances the state by one.
- Accepting a word in S_D has these effects on that same edge:
  - a<=sa, b<=sb, c<=sc, d<=in_data.
  - op_valid<=1.
  - issue_cnt increments.
  - State returns to S_A.
- a..d change only on a launch edge. They hold the last set at all other times, including while the next set is being loaded.
- op_valid is 1 for exactly one cycle per launch. Back-to-back launches are at most one per 4 accepted words.
- flush = 1 forces the state to S_A on the next edge and drops any word presented that cycle. Flush wins over a simultaneous in_valid.
- flush leaves unchanged: a..d, the latency tracker and issue_cnt.
- Latency tracker: shift register vsr[LAT-1:0].
  - Every edge: vsr[0]<=op_valid and vsr[i]<=vsr[i-1].
  - res_valid = vsr[LAT-1].
- in_flight = popcount(op_valid, vsr[LAT-2:0]).
- The loader never stalls the pipeline. The pipeline samples a..d on every edge. Only edges flagged by op_valid are meaningful.
- Arithmetic: issue_cnt wraps from 2^CW-1 to 0. The loader performs no operand arithmetic.

## Timing
- Reset (rst_n low, takes effect asynchronously):
  - a = b = c = d = 0.
  - op_valid = 0, res_valid = 0.
  - vsr = 0, in_flight = 0, issue_cnt = 0.
  - State S_A, shadow registers 0.
- in_ready = 1 after reset, unless flush is high.
- Word-to-launch timing: if d is accepted on edge k, op_valid and the new a..d are visible in cycle k+1. The pipeline samples them on edge k+1.
- Result timing: res_valid is high in cycle k+LAT+1, and the pipeline's f is valid in that same cycle. With LAT = 3 this is four cycles after the d word is accepted.
- Minimum launch interval is 4 cycles, with in_valid held high and issue_en = 1.
- issue_en low in S_D: the d word is held off (in_ready = 0) with no state change. It is accepted on the first edge where issue_en = 1.
- Reset asserted mid-set or mid-flight: all tracking clears at once. Results still in the pipeline are never flagged by res_valid.

## Test plan
- Basic launch:
  - Stimulus: after reset, stream 10, 20, 15, 25 continuously.
  - Required: op_valid pulses once with a=10, b=20, c=15, d=25. res_valid rises 3 cycles later with f = 45. issue_cnt = 1.
- Back-to-back sets:
  - Stimulus: stream 10, 20, 15, 25, then 15, 10, 13, 20.
  - Required: op_valid pulses 4 cycles apart. res_valid pulses 4 cycles apart with f = 45, then f = 38 (c-d wraps mod 2^10). in_flight never exceeds 1.
- issue_en hold-off:
  - Stimulus: issue_en = 0 while in S_D for 5 cycles.
  - Required: in_ready = 0 and a..d unchanged during the hold-off. The launch occurs on the edge after issue_en rises.
- Flush:
  - Stimulus: send 1, 2, assert flush for one cycle, then send 3, 4, 5, 6.
  - Required: the launched set is a=3, b=4, c=5, d=6, with no launch containing 1 or 2. A word presented during flush is dropped.
- Reset mid-flight:
  - Stimulus: complete a launch, then assert rst_n = 0 one cycle later.
  - Required: every output reads 0 immediately. res_valid never rises for that set.
- Counter wrap:
  - Stimulus: CW = 2, issue 5 sets.
  - Required: issue_cnt reads 0 after 4 launches and 1 after 5.

Source files
------------

// File: rtl/pipe_operand_loader.sv
// Operand feeder for the pipe_ex pipeline: gathers a, b, c, d words from a
// valid/ready stream, launches them as one registered set, and tracks results.
module pipe_operand_loader #(
  parameter int N   = 10,
  parameter int LAT = 3,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  input  logic          issue_en,
  input  logic          flush,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  output logic [N-1:0]  c,
  output logic [N-1:0]  d,
  output logic          op_valid,
  output logic          res_valid,
  output logic [1:0]    in_flight,
  output logic [CW-1:0] issue_cnt
);

  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_C = 2'd2,
    S_D = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           accept_s;
  logic           launch_s;
  logic [N-1:0]   sa_r;
  logic [N-1:0]   sb_r;
  logic [N-1:0]   sc_r;
  logic [LAT-1:0] vsr_r;

  function automatic logic [1:0] count_ones(input logic [LAT-1:0] v);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < LAT; i++) begin
      n = n + {1'b0, v[i]};
    end
    return n;
  endfunction

  // Handshake and next-state: only the d word waits for issue_en; flush overrides all.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    accept_s    = 1'b0;
    launch_s    = 1'b0;
    case (state_r)
      S_A, S_B, S_C: in_ready = !flush;
      S_D:           in_ready = issue_en && !flush;
      default:       in_ready = 1'b0;
    endcase
    accept_s = in_valid && in_ready;
    if (flush) begin
      state_nxt_s = S_A;
    end else if (accept_s) begin
      case (state_r)
        S_A:     state_nxt_s = S_B;
        S_B:     state_nxt_s = S_C;
        S_C:     state_nxt_s = S_D;
        S_D: begin
          state_nxt_s = S_A;
          launch_s    = 1'b1;
        end
        default: state_nxt_s = S_A;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shadow registers hold the first three words until the set is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r <= '0;
      sb_r <= '0;
      sc_r <= '0;
    end else if (accept_s) begin
      case (state_r)
        S_A:     sa_r <= in_data;
        S_B:     sb_r <= in_data;
        S_C:     sc_r <= in_data;
        default: sa_r <= sa_r;
      endcase
    end
  end

  // Launch registers: a..d move only on a launch so the pipeline sees a stable set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      op_valid  <= 1'b0;
      issue_cnt <= '0;
    end else begin
      op_valid <= launch_s;
      if (launch_s) begin
        a         <= sa_r;
        b         <= sb_r;
        c         <= sc_r;
        d         <= in_data;
        issue_cnt <= issue_cnt + CW'(1);
      end
    end
  end

  // Latency tracker follows each launch through the pipeline depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_r <= '0;
    end else begin
      vsr_r <= {vsr_r[LAT-2:0], op_valid};
    end
  end

  assign res_valid = vsr_r[LAT-1];
  assign in_flight = count_ones({vsr_r[LAT-2:0], op_valid});

endmodule

// File: tb/tb_pipe_operand_loader.sv
// Self-checking bench for pipe_operand_loader: directed scenarios plus random
// traffic, compared against a word-list/launch-time reference model.
module tb_pipe_operand_loader;
  localparam int N   = 10;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          issue_en = 1'b1;
  logic          flush = 1'b0;
  logic          in_ready, op_valid, res_valid;
  logic [N-1:0]  a, b, c, d;
  logic [1:0]    in_flight;
  logic [7:0]    issue_cnt;
  logic          in_ready2, op_valid2, res_valid2;
  logic [N-1:0]  a2, b2, c2, d2;
  logic [1:0]    in_flight2;
  logic [1:0]    issue_cnt2;

  pipe_operand_loader #(.N(N), .LAT(LAT), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .issue_en(issue_en), .flush(flush),
    .a(a), .b(b), .c(c), .d(d), .op_valid(op_valid), .res_valid(res_valid),
    .in_flight(in_flight), .issue_cnt(issue_cnt)
  );

  pipe_operand_loader #(.N(N), .LAT(LAT), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .issue_en(issue_en), .flush(flush),
    .a(a2), .b(b2), .c(c2), .d(d2), .op_valid(op_valid2), .res_valid(res_valid2),
    .in_flight(in_flight2), .issue_cnt(issue_cnt2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pend[$];
  int launches[$];
  int exp_a = 0, exp_b = 0, exp_c = 0, exp_d = 0, exp_cnt = 0;
  int max_if = 0;
  logic [N-1:0] f1, hold_a, hold_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit launched_at(input int t);
    foreach (launches[i]) if (launches[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int flight_at(input int t);
    int n = 0;
    foreach (launches[i]) if (launches[i] <= t && t < launches[i] + LAT) n++;
    return n;
  endfunction

  function automatic logic [N-1:0] fcalc(input int fa, input int fb, input int fc, input int fd);
    int s;
    s = (fa + fb) + (fc - fd) + fd;
    return N'(s & ((1 << N) - 1));
  endfunction

  // One clock cycle: drive, check in_ready mid-cycle, update model, check outputs.
  task automatic step(input bit v, input int data, input bit ie, input bit fl);
    bit rdy;
    in_valid = v; in_data = N'(data); issue_en = ie; flush = fl;
    @(negedge clk);
    rdy = !fl && (pend.size() < 3 || ie);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("in_ready_cw2", {31'd0, in_ready2}, {31'd0, rdy});
    @(posedge clk);
    cyc++;
    if (fl) pend.delete();
    else if (v && rdy) begin
      if (pend.size() < 3) pend.push_back(data);
      else begin
        exp_a = pend[0]; exp_b = pend[1]; exp_c = pend[2]; exp_d = data;
        pend.delete();
        launches.push_back(cyc);
        exp_cnt++;
      end
    end
    #1;
    chk("a", 32'(a), 32'(exp_a));
    chk("b", 32'(b), 32'(exp_b));
    chk("c", 32'(c), 32'(exp_c));
    chk("d", 32'(d), 32'(exp_d));
    chk("op_valid", {31'd0, op_valid}, {31'd0, launched_at(cyc)});
    chk("res_valid", {31'd0, res_valid}, {31'd0, launched_at(cyc - LAT)});
    chk("in_flight", 32'(in_flight), 32'(flight_at(cyc)));
    chk("issue_cnt", 32'(issue_cnt), 32'(exp_cnt % 256));
    chk("issue_cnt_cw2", 32'(issue_cnt2), 32'(exp_cnt % 4));
    if (int'(in_flight) > max_if) max_if = int'(in_flight);
  endtask

  task automatic send4(input int w0, input int w1, input int w2, input int w3);
    step(1'b1, w0, 1'b1, 1'b0);
    step(1'b1, w1, 1'b1, 1'b0);
    step(1'b1, w2, 1'b1, 1'b0);
    step(1'b1, w3, 1'b1, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; issue_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_in_flight", 32'(in_flight), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_issue_cnt_cw2", 32'(issue_cnt2), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    pend.delete(); launches.delete();
    exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0; exp_cnt = 0;
    @(posedge clk); cyc++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); cyc++;
    #1;
  endtask

  initial begin
    @(posedge clk);
    do_reset();

    // Basic launch: 10,20,15,25 -> f = 45 three cycles after op_valid.
    send4(10, 20, 15, 25);
    chk("basic_op_valid", {31'd0, op_valid}, 32'd1);
    chk("basic_a", 32'(a), 32'd10);
    chk("basic_d", 32'(d), 32'd25);
    chk("basic_f", 32'(fcalc(int'(a), int'(b), int'(c), int'(d))), 32'd45);
    chk("basic_cnt", 32'(issue_cnt), 32'd1);
    repeat (3) step(1'b0, 0, 1'b1, 1'b0);
    chk("basic_res_valid", {31'd0, res_valid}, 32'd1);

    // Back-to-back sets; second result wraps through c-d.
    max_if = 0;
    send4(10, 20, 15, 25);
    f1 = fcalc(int'(a), int'(b), int'(c), int'(d));
    send4(15, 10, 13, 20);
    chk("b2b_f1", 32'(f1), 32'd45);
    chk("b2b_op_valid", {31'd0, op_valid}, 32'd1);
    chk("b2b_f2", 32'(fcalc(int'(a), int'(b), int'(c), int'(d))), 32'd38);
    repeat (4) step(1'b0, 0, 1'b1, 1'b0);
    chk("b2b_max_in_flight", 32'(max_if), 32'd1);

    // issue_en hold-off while the d word is waiting.
    step(1'b1, 1, 1'b1, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    hold_a = a; hold_d = d;
    repeat (5) step(1'b1, 4, 1'b0, 1'b0);
    chk("hold_a", 32'(a), 32'(hold_a));
    chk("hold_d", 32'(d), 32'(hold_d));
    chk("hold_no_launch", {31'd0, op_valid}, 32'd0);
    step(1'b1, 4, 1'b1, 1'b0);
    chk("hold_launch", {31'd0, op_valid}, 32'd1);
    chk("hold_launch_d", 32'(d), 32'd4);

    // Flush drops the partial set and the word offered with it.
    step(1'b1, 1, 1'b1, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0);
    step(1'b1, 99, 1'b1, 1'b1);
    send4(3, 4, 5, 6);
    chk("flush_op_valid", {31'd0, op_valid}, 32'd1);
    chk("flush_a", 32'(a), 32'd3);
    chk("flush_b", 32'(b), 32'd4);
    chk("flush_c", 32'(c), 32'd5);
    chk("flush_d", 32'(d), 32'd6);

    // Reset one cycle after a launch: the in-flight result is never flagged.
    send4(7, 8, 9, 10);
    step(1'b0, 0, 1'b1, 1'b0);
    do_reset();
    repeat (5) begin
      step(1'b0, 0, 1'b1, 1'b0);
      chk("rst_flight_res_valid", {31'd0, res_valid}, 32'd0);
    end

    // Counter wrap on the CW=2 instance.
    repeat (4) send4(1, 2, 3, 4);
    chk("wrap_after4", 32'(issue_cnt2), 32'd0);
    send4(5, 6, 7, 8);
    chk("wrap_after5", 32'(issue_cnt2), 32'd1);
    chk("wrap_cw8", 32'(issue_cnt), 32'd5);

    // Random traffic with occasional hold-off and flush.
    repeat (400) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (LAT + 1) step(1'b0, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
